rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq_ctrl
//  Purpose  : Power-up / reset sequencer. Qualifies PLL lock, enables the
//             downstream gated clocks, releases per-domain resets one at a
//             time (bit 0 first), and re-asserts them in reverse order on
//             shutdown before dropping the clock enable.
//  Option   : RST_SEQ_TIMEOUT_EN - enables the WAIT_LOCK timeout and FAULT
//             state; when undefined WAIT_LOCK waits forever, fault is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
   parameter int N_DOM     = 3,
   parameter int INIT_DLY  = 50,
   parameter int LOCK_FILT = 8,
   parameter int GAP       = 16,
   parameter int TIMEOUT   = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             locked,
   output logic [N_DOM-1:0] seq_rst,
   output logic             clk_en,
   output logic             ready,
   output logic             lock_lost,
   output logic             fault,
   output logic [2:0]       state_o
);

   localparam int C_MAX_IG  = (INIT_DLY > GAP) ? INIT_DLY : GAP;
   localparam int C_MAX_ALL = (C_MAX_IG > TIMEOUT) ? C_MAX_IG : TIMEOUT;
   localparam int C_CNT_W   = $clog2(C_MAX_ALL + 1);
   localparam int C_LCK_W   = $clog2(LOCK_FILT + 1);
   localparam int C_IDX_W   = $clog2(N_DOM + 1);

   localparam logic [C_CNT_W-1:0] C_INIT_LAST = C_CNT_W'(INIT_DLY - 1);
   localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(GAP - 1);
   localparam logic [C_LCK_W-1:0] C_LOCK_LAST = C_LCK_W'(LOCK_FILT - 1);
   localparam logic [C_IDX_W-1:0] C_IDX_LAST  = C_IDX_W'(N_DOM - 1);
   localparam logic [C_IDX_W-1:0] C_IDX_ALL   = C_IDX_W'(N_DOM);
   localparam logic [N_DOM-1:0]   C_BIT0      = N_DOM'(1);
`ifdef RST_SEQ_TIMEOUT_EN
   localparam logic [C_CNT_W-1:0] C_TO_LAST   = C_CNT_W'(TIMEOUT - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INIT      = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4,
      S_SHUTDOWN  = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic [C_CNT_W-1:0]   cnt_q, cnt_d;
   logic [C_LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic [C_IDX_W-1:0]   idx_q, idx_d;
   logic [N_DOM-1:0]     seq_rst_q, seq_rst_d;
   logic                 clk_en_q, clk_en_d;
   logic                 ready_q, ready_d;
   logic                 lock_lost_q, lock_lost_d;
   logic                 lk_meta_q, lk_s_q;
   logic                 w_lock_loss;
   logic [C_IDX_W-1:0]   w_rel_cnt;
`ifdef RST_SEQ_TIMEOUT_EN
   logic                 fault_q, fault_d;
`endif

   // Two-flop synchronizer for the asynchronous PLL lock input
   always_ff @(posedge clk) begin
      if (reset) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
      end else begin
         lk_meta_q <= locked;
         lk_s_q    <= lk_meta_q;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lock_cnt_q  <= '0;
         idx_q       <= '0;
         seq_rst_q   <= '1;
         clk_en_q    <= 1'b0;
         ready_q     <= 1'b0;
         lock_lost_q <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         idx_q       <= idx_d;
         seq_rst_q   <= seq_rst_d;
         clk_en_q    <= clk_en_d;
         ready_q     <= ready_d;
         lock_lost_q <= lock_lost_d;
`ifdef RST_SEQ_TIMEOUT_EN
         fault_q     <= fault_d;
`endif
      end
   end

   // Next-state and output decode; lock loss beats start low beats progress
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lock_cnt_d  = lock_cnt_q;
      idx_d       = idx_q;
      seq_rst_d   = seq_rst_q;
      clk_en_d    = clk_en_q;
      ready_d     = ready_q;
      lock_lost_d = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      fault_d     = fault_q;
`endif
      w_lock_loss = !lk_s_q && (state_q == S_RELEASE || state_q == S_RUN ||
                                state_q == S_SHUTDOWN);
      // RUN keeps idx at 0, so the number of released domains is implied
      w_rel_cnt   = (state_q == S_RUN) ? C_IDX_ALL : idx_q;

      if (w_lock_loss) begin
         seq_rst_d   = '1;
         clk_en_d    = 1'b0;
         ready_d     = 1'b0;
         lock_lost_d = 1'b1;
         cnt_d       = '0;
         lock_cnt_d  = '0;
         idx_d       = '0;
         state_d     = start ? S_WAIT_LOCK : S_IDLE;
      end else if (!start && (state_q == S_RELEASE || state_q == S_RUN)) begin
         // Shutdown entry: re-assert the highest released domain right away
         state_d = S_SHUTDOWN;
         ready_d = 1'b0;
         cnt_d   = '0;
         if (w_rel_cnt != '0) begin
            seq_rst_d = seq_rst_q | (C_BIT0 << (w_rel_cnt - 1'b1));
            idx_d     = w_rel_cnt - 1'b1;
         end else begin
            idx_d     = '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_INIT;
                  cnt_d   = '0;
               end
            end
            S_INIT: begin
               if (!start) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == C_INIT_LAST) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               if (!start) begin
                  state_d    = S_IDLE;
                  cnt_d      = '0;
                  lock_cnt_d = '0;
               end else if (lk_s_q && lock_cnt_q == C_LOCK_LAST) begin
                  state_d    = S_RELEASE;
                  clk_en_d   = 1'b1;
                  cnt_d      = '0;
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lk_s_q ? lock_cnt_q + 1'b1 : '0;
`ifdef RST_SEQ_TIMEOUT_EN
                  // Dwell counter: give up after TIMEOUT unqualified cycles
                  if (cnt_q == C_TO_LAST) begin
                     state_d    = S_FAULT;
                     fault_d    = 1'b1;
                     seq_rst_d  = '1;
                     clk_en_d   = 1'b0;
                     cnt_d      = '0;
                     lock_cnt_d = '0;
                  end else begin
                     cnt_d      = cnt_q + 1'b1;
                  end
`endif
               end
            end
            S_RELEASE: begin
               if (cnt_q == C_GAP_LAST) begin
                  seq_rst_d = seq_rst_q & ~(C_BIT0 << idx_q);
                  cnt_d     = '0;
                  if (idx_q == C_IDX_LAST) begin
                     state_d = S_RUN;
                     ready_d = 1'b1;
                     idx_d   = '0;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               state_d = S_RUN;
            end
            S_SHUTDOWN: begin
               // start is deliberately ignored until IDLE is reached
               if (cnt_q == C_GAP_LAST) begin
                  cnt_d = '0;
                  if (idx_q != '0) begin
                     seq_rst_d = seq_rst_q | (C_BIT0 << (idx_q - 1'b1));
                     idx_d     = idx_q - 1'b1;
                  end else begin
                     clk_en_d  = 1'b0;
                     state_d   = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`ifdef RST_SEQ_TIMEOUT_EN
            S_FAULT: begin
               if (!start) begin
                  state_d = S_IDLE;
                  fault_d = 1'b0;
               end
            end
`endif
            default: begin
               state_d    = S_IDLE;
               cnt_d      = '0;
               lock_cnt_d = '0;
               idx_d      = '0;
               seq_rst_d  = '1;
               clk_en_d   = 1'b0;
               ready_d    = 1'b0;
            end
         endcase
      end
   end

   assign seq_rst   = seq_rst_q;
   assign clk_en    = clk_en_q;
   assign ready     = ready_q;
   assign lock_lost = lock_lost_q;
   assign state_o   = state_q;
`ifdef RST_SEQ_TIMEOUT_EN
   assign fault     = fault_q;
`else
   assign fault     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_seq_ctrl
//  Purpose  : Self-checking bench for rst_seq_ctrl: vector table plus a
//             hand-written timeout sequence (RST_SEQ_TIMEOUT_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_INIT = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_REL  = 3'd3;
   localparam logic [2:0] ST_RUN  = 3'd4;
   localparam logic [2:0] ST_SHUT = 3'd5;
   localparam logic [2:0] ST_FLT  = 3'd6;

   logic       clk = 1'b0;
   logic       reset, start, locked;
   logic [2:0] seq_rst;
   logic       clk_en, ready, lock_lost, fault;
   logic [2:0] state_o;

   rst_seq_ctrl #(
      .N_DOM(3), .INIT_DLY(50), .LOCK_FILT(8), .GAP(16), .TIMEOUT(64)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .locked(locked),
      .seq_rst(seq_rst), .clk_en(clk_en), .ready(ready),
      .lock_lost(lock_lost), .fault(fault), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       start;
      logic       locked;
      int         dly;
      logic [2:0] st;
      logic [2:0] seq;
      logic       en;
      logic       rdy;
      logic       ll;
   } vec_t;

   typedef struct {
      int         id;
      logic [9:0] exp;
   } sb_t;

   vec_t vecs[48];
   int   nrows = 0;
   sb_t  sb[$];
   int   total = 0;
   int   bad   = 0;
   int   ll_cnt = 0;

   // lock_lost pulses, sampled away from the active edge
   always @(negedge clk) if (lock_lost === 1'b1) ll_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before 1ms");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, s, l, input int d, input logic [2:0] st,
                      input logic [2:0] sq, input logic en, rdy, ll);
      vecs[nrows].rst = r;   vecs[nrows].start = s; vecs[nrows].locked = l;
      vecs[nrows].dly = d;   vecs[nrows].st = st;   vecs[nrows].seq = sq;
      vecs[nrows].en  = en;  vecs[nrows].rdy = rdy; vecs[nrows].ll = ll;
      nrows++;
   endtask

   task automatic push_exp(input int id, input logic [2:0] st, input logic [2:0] sq,
                           input logic en, rdy, ll, flt);
      sb_t e;
      e.id  = id;
      e.exp = {st, sq, en, rdy, ll, flt};
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag);
      sb_t        e;
      logic [9:0] act;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, got no expectation", tag);
      end else begin
         e   = sb.pop_front();
         act = {state_o, seq_rst, clk_en, ready, lock_lost, fault};
         if (act !== e.exp) begin
            bad++;
            $display("FAIL %s id=%0d: got st=%0d seq=%b en=%b rdy=%b ll=%b flt=%b, want st=%0d seq=%b en=%b rdy=%b ll=%b flt=%b",
                     tag, e.id, act[9:7], act[6:4], act[3], act[2], act[1], act[0],
                     e.exp[9:7], e.exp[6:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
         end
      end
   endtask

   task automatic check_int(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         reset  = vecs[i].rst;
         start  = vecs[i].start;
         locked = vecs[i].locked;
         push_exp(i, vecs[i].st, vecs[i].seq, vecs[i].en, vecs[i].rdy, vecs[i].ll, 1'b0);
         tick(vecs[i].dly);
         check_out($sformatf("row%0d", i));
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; locked = 1'b1;

      // Reset, then bring-up with lock held high (offsets from start edge)
      add(1,0,1, 3, ST_IDLE, 3'b111, 0,0,0);   // 0  reset values
      add(0,1,1, 1, ST_INIT, 3'b111, 0,0,0);   // 1  E0
      add(0,1,1,49, ST_INIT, 3'b111, 0,0,0);   // 2  E0+49
      add(0,1,1, 1, ST_WAIT, 3'b111, 0,0,0);   // 3  E0+50
      add(0,1,1, 7, ST_WAIT, 3'b111, 0,0,0);   // 4  E0+57
      add(0,1,1, 1, ST_REL,  3'b111, 1,0,0);   // 5  E0+58
      add(0,1,1,15, ST_REL,  3'b111, 1,0,0);   // 6  E0+73
      add(0,1,1, 1, ST_REL,  3'b110, 1,0,0);   // 7  E0+74
      add(0,1,1,15, ST_REL,  3'b110, 1,0,0);   // 8  E0+89
      add(0,1,1, 1, ST_REL,  3'b100, 1,0,0);   // 9  E0+90
      add(0,1,1,15, ST_REL,  3'b100, 1,0,0);   // 10 E0+105
      add(0,1,1, 1, ST_RUN,  3'b000, 1,1,0);   // 11 E0+106
      // Lock loss in RUN, then recovery (F = lock restored)
      add(0,1,0, 2, ST_RUN,  3'b000, 1,1,0);   // 12 sync latency
      add(0,1,0, 1, ST_WAIT, 3'b111, 0,0,1);   // 13 third edge
      add(0,1,0, 1, ST_WAIT, 3'b111, 0,0,0);   // 14 pulse is one cycle
      add(0,1,1, 9, ST_WAIT, 3'b111, 0,0,0);   // 15 F+9
      add(0,1,1, 1, ST_REL,  3'b111, 1,0,0);   // 16 F+10
      add(0,1,1,16, ST_REL,  3'b110, 1,0,0);   // 17 F+26
      add(0,1,1,16, ST_REL,  3'b100, 1,0,0);   // 18 F+42
      add(0,1,1,16, ST_RUN,  3'b000, 1,1,0);   // 19 F+58
      // Shutdown from RUN with a start pulse in the middle
      add(0,0,1, 1, ST_SHUT, 3'b100, 1,0,0);   // 20 S
      add(0,1,1, 1, ST_SHUT, 3'b100, 1,0,0);   // 21 start pulse ignored
      add(0,0,1,14, ST_SHUT, 3'b100, 1,0,0);   // 22 S+15
      add(0,0,1, 1, ST_SHUT, 3'b110, 1,0,0);   // 23 S+16
      add(0,0,1,16, ST_SHUT, 3'b111, 1,0,0);   // 24 S+32
      add(0,0,1,15, ST_SHUT, 3'b111, 1,0,0);   // 25 S+47
      add(0,0,1, 1, ST_IDLE, 3'b111, 0,0,0);   // 26 S+48
      add(0,0,1, 1, ST_IDLE, 3'b111, 0,0,0);   // 27 stays idle
      // Lock glitch inside WAIT_LOCK (offsets from new start edge)
      add(0,1,0, 1, ST_INIT, 3'b111, 0,0,0);   // 28 E0
      add(0,1,0,49, ST_INIT, 3'b111, 0,0,0);   // 29 E0+49
      add(0,1,0, 1, ST_WAIT, 3'b111, 0,0,0);   // 30 E0+50
      add(0,1,1, 5, ST_WAIT, 3'b111, 0,0,0);   // 31 high 5 cycles
      add(0,1,0, 1, ST_WAIT, 3'b111, 0,0,0);   // 32 low 1 cycle
      add(0,1,1, 4, ST_WAIT, 3'b111, 0,0,0);   // 33 E0+60, no early qualify
      add(0,1,1, 5, ST_WAIT, 3'b111, 0,0,0);   // 34 E0+65
      add(0,1,1, 1, ST_REL,  3'b111, 1,0,0);   // 35 E0+66 = lk_s rise + 8
      add(0,1,1,16, ST_REL,  3'b110, 1,0,0);   // 36 mid-release
      // Reset mid-RELEASE, bring-up restarts
      add(1,1,1, 1, ST_IDLE, 3'b111, 0,0,0);   // 37
      add(0,1,1, 1, ST_INIT, 3'b111, 0,0,0);   // 38
      add(0,1,0,50, ST_WAIT, 3'b111, 0,0,0);   // 39 enter WAIT, lock held low

      run_rows(0, 11);
      check_int("no_lock_lost_bringup", ll_cnt, 0);
      run_rows(12, 19);
      check_int("one_lock_lost_pulse", ll_cnt, 1);
      run_rows(20, 39);

      // Timeout: lock held low from WAIT_LOCK entry (W = row 39 edge)
      start = 1'b1; locked = 1'b0;
      push_exp(100, ST_WAIT, 3'b111, 0,0,0,0);
      tick(63);
      check_out("wait_w63");
`ifdef RST_SEQ_TIMEOUT_EN
      push_exp(101, ST_FLT, 3'b111, 0,0,0,1);
      tick(1);
      check_out("fault_w64");
      push_exp(102, ST_FLT, 3'b111, 0,0,0,1);
      tick(5);
      check_out("fault_hold");
      start = 1'b0;
      push_exp(103, ST_IDLE, 3'b111, 0,0,0,0);
      tick(1);
      check_out("fault_clear");
`else
      push_exp(101, ST_WAIT, 3'b111, 0,0,0,0);
      tick(1);
      check_out("nofault_w64");
      push_exp(102, ST_WAIT, 3'b111, 0,0,0,0);
      tick(200);
      check_out("nofault_long");
      start = 1'b0;
      push_exp(103, ST_IDLE, 3'b111, 0,0,0,0);
      tick(1);
      check_out("wait_abort");
`endif
      check_int("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
